// File: rtl/button_array.sv
// ---------------------------------------------------------------------------
// button_array
// N-channel pushbutton conditioner. Each channel synchronises a raw key,
// normalises its polarity, debounces it with a stability counter and emits
// single-cycle press / release pulses, with optional auto-repeat while held.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset          synchronous active-low reset (0 = reset)
//   btn_in         raw asynchronous key inputs, one bit per channel
//   rpt_en         per-channel auto-repeat enable
//   level          debounced pressed state (1 = pressed), registered
//   press_pulse    one-cycle pulse on press and on each auto-repeat, registered
//   release_pulse  one-cycle pulse on debounced release, registered
//   any_press      OR of press_pulse (combinational from registered pulses)
// ---------------------------------------------------------------------------
module button_array #(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_RATE     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_BTN-1:0] rpt_en,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic             any_press
);

    // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // Repeat counter must hold the larger of the two intervals itself.
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW      = $clog2(RPT_MAX + 1);

    // Raw-key value that means "not pressed"; synchronisers reset to it.
    localparam logic L_INACTIVE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    // Elaboration-time guard against illegal parameter values.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_array: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES == 0) begin : g_bad_deb
        $error("button_array: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_bad_rpt
        $error("button_array: REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    genvar g;
    for (g = 0; g < N_BTN; g++) begin : g_ch

        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;
        logic [DW-1:0]          r_dcnt;
        logic                   r_level;
        logic                   r_level_d;
        logic                   w_rise;
        logic                   w_fall;
        rpt_state_t             r_state;
        rpt_state_t             w_state_nxt;
        logic [RW-1:0]          r_rcnt;
        logic [RW-1:0]          w_rcnt_nxt;
        logic                   w_press_nxt;
        logic                   w_release_nxt;
        logic                   r_press;
        logic                   r_release;

        // Synchroniser chain; bit 0 samples the asynchronous key.
        always_ff @(posedge clk) begin
            if (!reset) begin
                r_sync <= {SYNC_STAGES{L_INACTIVE}};
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in[g]};
            end
        end

        // Polarity-normalised synchronised sample, 1 = pressed.
        assign w_s = (ACTIVE_LOW != 0) ? ~r_sync[SYNC_STAGES-1] : r_sync[SYNC_STAGES-1];

        // Debounce: level follows w_s only after DEBOUNCE_CYCLES consecutive
        // disagreeing samples; any agreeing sample restarts the count.
        always_ff @(posedge clk) begin
            if (!reset) begin
                r_dcnt    <= '0;
                r_level   <= 1'b0;
                r_level_d <= 1'b0;
            end else begin
                r_level_d <= r_level;
                if (w_s == r_level) begin
                    r_dcnt <= '0;
                end else if (r_dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    r_level <= w_s;
                    r_dcnt  <= '0;
                end else begin
                    r_dcnt <= r_dcnt + DW'(1);
                end
            end
        end

        // Edges of the debounced level, seen one cycle after level moves.
        assign w_rise = r_level & ~r_level_d;
        assign w_fall = ~r_level & r_level_d;

        // Repeat FSM state and pulse registers.
        always_ff @(posedge clk) begin
            if (!reset) begin
                r_state   <= ST_IDLE;
                r_rcnt    <= '0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_rcnt    <= w_rcnt_nxt;
                r_press   <= w_press_nxt;
                r_release <= w_release_nxt;
            end
        end

        // Repeat FSM next state; a release always takes priority over a
        // repeat expiry on the same edge.
        always_comb begin
            w_state_nxt   = r_state;
            w_rcnt_nxt    = r_rcnt;
            w_press_nxt   = 1'b0;
            w_release_nxt = w_fall;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_press_nxt = 1'b1;
                        if (rpt_en[g]) begin
                            w_state_nxt = ST_DELAY;
                            w_rcnt_nxt  = RW'(1);
                        end
                    end
                end
                ST_DELAY: begin
                    if (w_fall || !rpt_en[g]) begin
                        w_state_nxt = ST_IDLE;
                        w_rcnt_nxt  = '0;
                    end else if (r_rcnt == RW'(REPEAT_DELAY)) begin
                        w_press_nxt = 1'b1;
                        w_state_nxt = ST_REPEAT;
                        w_rcnt_nxt  = RW'(1);
                    end else begin
                        w_rcnt_nxt = r_rcnt + RW'(1);
                    end
                end
                ST_REPEAT: begin
                    if (w_fall || !rpt_en[g]) begin
                        w_state_nxt = ST_IDLE;
                        w_rcnt_nxt  = '0;
                    end else if (r_rcnt == RW'(REPEAT_RATE)) begin
                        w_press_nxt = 1'b1;
                        w_rcnt_nxt  = RW'(1);
                    end else begin
                        w_rcnt_nxt = r_rcnt + RW'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_rcnt_nxt  = '0;
                end
            endcase
        end

        assign level[g]         = r_level;
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_release;
    end

    assign any_press = |press_pulse;

endmodule

// File: tb/tb_button_array.sv
// ---------------------------------------------------------------------------
// tb_button_array
// Directed self-checking bench for button_array at default parameters.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, so after "step" number s the DUT has seen edges 0..s-1 of a phase.
// ---------------------------------------------------------------------------
module tb_button_array;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_in;
    logic [N-1:0] rpt_en;
    logic [N-1:0] level;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic         any_press;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    button_array #(
        .N_BTN          (N),
        .ACTIVE_LOW     (1),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (16),
        .REPEAT_RATE    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .rpt_en       (rpt_en),
        .level        (level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .any_press    (any_press)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks all four outputs against expected values.
    task automatic chk_all(input string tag, input logic [3:0] e_lvl, input logic [3:0] e_prs,
                           input logic [3:0] e_rel);
        chk({tag, "_level"}, 32'(level), 32'(e_lvl));
        chk({tag, "_press"}, 32'(press_pulse), 32'(e_prs));
        chk({tag, "_release"}, 32'(release_pulse), 32'(e_rel));
        chk({tag, "_any"}, 32'(any_press), 32'(|e_prs));
    endtask

    initial begin
        logic [3:0] e_lvl;
        logic [3:0] e_prs;
        logic [3:0] e_rel;

        // (1) Reset with all keys released, then idle.
        reset  = 1'b0;
        btn_in = 4'b1111;
        rpt_en = 4'b0000;
        repeat (3) step();
        chk_all("reset", 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            step();
            chk_all("idle", 4'b0000, 4'b0000, 4'b0000);
        end

        // (2) Single press on channel 0 held 12 cycles, then release.
        btn_in[0] = 1'b0;
        for (int s = 1; s <= 12; s++) begin
            step();
            e_lvl = (s >= 6) ? 4'b0001 : 4'b0000;
            e_prs = (s == 7) ? 4'b0001 : 4'b0000;
            chk_all("ch0_press", e_lvl, e_prs, 4'b0000);
        end
        btn_in[0] = 1'b1;
        for (int s = 1; s <= 10; s++) begin
            step();
            e_lvl = (s <= 5) ? 4'b0001 : 4'b0000;
            e_rel = (s == 7) ? 4'b0001 : 4'b0000;
            chk_all("ch0_release", e_lvl, 4'b0000, e_rel);
        end

        // (3) Short glitch and bounce on channel 1 are rejected.
        btn_in[1] = 1'b0;
        repeat (3) step();
        btn_in[1] = 1'b1;
        for (int s = 1; s <= 10; s++) begin
            step();
            chk_all("ch1_glitch", 4'b0000, 4'b0000, 4'b0000);
        end
        for (int b = 0; b < 5; b++) begin
            btn_in[1] = 1'b0;
            step();
            chk_all("ch1_bounce", 4'b0000, 4'b0000, 4'b0000);
            step();
            chk_all("ch1_bounce", 4'b0000, 4'b0000, 4'b0000);
            btn_in[1] = 1'b1;
            step();
            chk_all("ch1_bounce", 4'b0000, 4'b0000, 4'b0000);
        end
        btn_in[1] = 1'b0;
        for (int s = 1; s <= 10; s++) begin
            step();
            e_lvl = (s >= 6) ? 4'b0010 : 4'b0000;
            e_prs = (s == 7) ? 4'b0010 : 4'b0000;
            chk_all("ch1_steady", e_lvl, e_prs, 4'b0000);
        end
        btn_in[1] = 1'b1;
        for (int s = 1; s <= 10; s++) begin
            step();
            e_lvl = (s <= 5) ? 4'b0010 : 4'b0000;
            e_rel = (s == 7) ? 4'b0010 : 4'b0000;
            chk_all("ch1_release", e_lvl, 4'b0000, e_rel);
        end

        // (4a) Auto-repeat on channel 2, held 40 cycles. The repeat that
        // would fall on the release-detect edge (step 47) is suppressed.
        rpt_en[2] = 1'b1;
        btn_in[2] = 1'b0;
        for (int s = 1; s <= 60; s++) begin
            if (s == 41) btn_in[2] = 1'b1;
            step();
            e_lvl = (s >= 6 && s <= 45) ? 4'b0100 : 4'b0000;
            e_prs = ((s == 7) || (s >= 23 && s <= 43 && ((s - 23) % 4) == 0)) ? 4'b0100 : 4'b0000;
            e_rel = (s == 47) ? 4'b0100 : 4'b0000;
            chk_all("ch2_repeat", e_lvl, e_prs, e_rel);
        end

        // (4b) Dropping rpt_en mid-REPEAT stops repeats; level stays high.
        btn_in[2] = 1'b0;
        for (int s = 1; s <= 50; s++) begin
            if (s == 29) rpt_en[2] = 1'b0;
            step();
            e_lvl = (s >= 6) ? 4'b0100 : 4'b0000;
            e_prs = (s == 7 || s == 23 || s == 27) ? 4'b0100 : 4'b0000;
            chk_all("ch2_rpt_off", e_lvl, e_prs, 4'b0000);
        end
        btn_in[2] = 1'b1;
        for (int s = 1; s <= 10; s++) begin
            step();
            e_lvl = (s <= 5) ? 4'b0100 : 4'b0000;
            e_rel = (s == 7) ? 4'b0100 : 4'b0000;
            chk_all("ch2_rpt_off_rel", e_lvl, 4'b0000, e_rel);
        end

        // (5) Channels 0 and 3 pressed in the same cycle.
        btn_in = 4'b0110;
        for (int s = 1; s <= 9; s++) begin
            step();
            e_lvl = (s >= 6) ? 4'b1001 : 4'b0000;
            e_prs = (s == 7) ? 4'b1001 : 4'b0000;
            chk_all("ch03_simul", e_lvl, e_prs, 4'b0000);
        end
        btn_in = 4'b1111;
        for (int s = 1; s <= 10; s++) begin
            step();
            e_lvl = (s <= 5) ? 4'b1001 : 4'b0000;
            e_rel = (s == 7) ? 4'b1001 : 4'b0000;
            chk_all("ch03_release", e_lvl, 4'b0000, e_rel);
        end

        // (6) Reset during REPEAT with channel 2 held, then re-detection.
        rpt_en[2] = 1'b1;
        btn_in[2] = 1'b0;
        for (int s = 1; s <= 30; s++) begin
            step();
            e_lvl = (s >= 6) ? 4'b0100 : 4'b0000;
            e_prs = (s == 7 || s == 23 || s == 27) ? 4'b0100 : 4'b0000;
            chk_all("ch2_pre_reset", e_lvl, e_prs, 4'b0000);
        end
        reset = 1'b0;
        for (int s = 1; s <= 3; s++) begin
            step();
            chk_all("mid_reset", 4'b0000, 4'b0000, 4'b0000);
        end
        reset = 1'b1;
        for (int s = 1; s <= 30; s++) begin
            step();
            e_lvl = (s >= 6) ? 4'b0100 : 4'b0000;
            e_prs = (s == 7 || s == 23 || s == 27) ? 4'b0100 : 4'b0000;
            chk_all("ch2_post_reset", e_lvl, e_prs, 4'b0000);
        end
        btn_in[2] = 1'b1;
        rpt_en    = 4'b0000;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
